// File: rtl/srt4_pkg.sv
// Shared types and constants for the radix-4 SRT divider control block.
// Optional divide-by-zero detection is enabled by defining SRT4_DIV0_DETECT_EN.
package srt4_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StInit,
        StNorm,
        StShift,
        StAdd,
        StCorrect,
        StResult,
        StDenorm,
        StDone
    } state_t;

    localparam int unsigned CTRL_W = 15;

    localparam int unsigned C0  = 0;
    localparam int unsigned C1  = 1;
    localparam int unsigned C2  = 2;
    localparam int unsigned C3  = 3;
    localparam int unsigned C4  = 4;
    localparam int unsigned C5  = 5;
    localparam int unsigned C6  = 6;
    localparam int unsigned C7  = 7;
    localparam int unsigned C8  = 8;
    localparam int unsigned C9  = 9;
    localparam int unsigned C10 = 10;
    localparam int unsigned C11 = 11;
    localparam int unsigned C12 = 12;
    localparam int unsigned C13 = 13;
    localparam int unsigned C14 = 14;

    localparam logic [2:0] ITER_COUNT = 3'd4;
    localparam logic [2:0] NORM_MAX   = 3'd7;

    // Quotient digit in sign/magnitude form, magnitude 0..2.
    typedef struct packed {
        logic       neg;
        logic [1:0] mag;
    } digit_t;

endpackage

// File: rtl/srt4_control_if.sv
// Handshake and strobe bundle between the SRT4 control FSM and its datapath/driver.
interface srt4_control_if;
    import srt4_pkg::*;

    logic              start;
    logic              b_msb;
    logic              b_zero;
    logic [2:0]        p_top;
    logic [CTRL_W-1:0] ctrl;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, b_msb, b_zero, p_top,
        input  ctrl, busy, done, err
    );

    modport slave (
        input  start, b_msb, b_zero, p_top,
        output ctrl, busy, done, err
    );

endinterface

// File: rtl/srt4_digit_sel.sv
// Radix-4 SRT quotient digit selection from the top three partial-remainder bits.
module srt4_digit_sel (
    input  logic [2:0] p_top,
    output logic       neg,
    output logic [1:0] mag
);

    always_comb begin
        neg = 1'b0;
        mag = 2'd0;
        case (p_top)
            3'b001: begin
                mag = 2'd1;
            end
            3'b010, 3'b011: begin
                mag = 2'd2;
            end
            3'b110: begin
                neg = 1'b1;
                mag = 2'd1;
            end
            3'b100, 3'b101: begin
                neg = 1'b1;
                mag = 2'd2;
            end
            default: begin
                neg = 1'b0;
                mag = 2'd0;
            end
        endcase
    end

endmodule

// File: rtl/srt4_control.sv
// Radix-4 SRT divider control FSM: normalise, four digit iterations, correct, denormalise.
// Define SRT4_DIV0_DETECT_EN to abort with err on a zero divisor during normalisation.
module srt4_control
    import srt4_pkg::*;
(
    input logic           clk,
    input logic           rst_n,
    srt4_control_if.slave bus
);

    state_t            state_q, state_d;
    logic [2:0]        iter_q, iter_d;
    logic [2:0]        norm_q, norm_d;
    digit_t            digit_q, digit_d;
    logic              err_q, err_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              busy_q;
    logic              done_q;

    logic              sel_neg;
    logic [1:0]        sel_mag;
    logic              div0;

    srt4_digit_sel u_digit_sel (
        .p_top (bus.p_top),
        .neg   (sel_neg),
        .mag   (sel_mag)
    );

`ifdef SRT4_DIV0_DETECT_EN
    assign div0 = bus.b_zero;
`else
    // Without detection a zero divisor simply runs the full sequence.
    logic unused_b_zero;
    assign unused_b_zero = bus.b_zero;
    assign div0          = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        norm_d  = norm_q;
        digit_d = digit_q;
        err_d   = err_q;
        ctrl_d  = '0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StInit;
                    err_d   = 1'b0;
                    iter_d  = 3'd0;
                    norm_d  = 3'd0;
                end
            end
            StInit: begin
                ctrl_d[C0] = 1'b1;
                ctrl_d[C1] = 1'b1;
                state_d    = StNorm;
            end
            StNorm: begin
                if (div0) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else if (!bus.b_msb && (norm_q < NORM_MAX)) begin
                    ctrl_d[C2] = 1'b1;
                    norm_d     = norm_q + 3'd1;
                end else begin
                    state_d = StShift;
                end
            end
            StShift: begin
                ctrl_d[C3] = 1'b1;
                unique case ({sel_neg, sel_mag})
                    3'b001:  ctrl_d[C4] = 1'b1;
                    3'b010:  ctrl_d[C7] = 1'b1;
                    3'b101:  ctrl_d[C5] = 1'b1;
                    3'b110:  ctrl_d[C6] = 1'b1;
                    default: ;
                endcase
                digit_d = '{neg: sel_neg, mag: sel_mag};
                if (iter_q < ITER_COUNT) begin
                    iter_d = iter_q + 3'd1;
                end
                if (sel_mag != 2'd0) begin
                    state_d = StAdd;
                end else if (iter_d == ITER_COUNT) begin
                    state_d = StCorrect;
                end else begin
                    state_d = StShift;
                end
            end
            StAdd: begin
                // Positive digit subtracts the divisor multiple, negative digit adds it.
                ctrl_d[C8]  = 1'b1;
                ctrl_d[C9]  = !digit_q.neg;
                ctrl_d[C10] = (digit_q.mag == 2'd2);
                state_d     = (iter_q == ITER_COUNT) ? StCorrect : StShift;
            end
            StCorrect: begin
                if (bus.p_top[2]) begin
                    ctrl_d[C8]  = 1'b1;
                    ctrl_d[C11] = 1'b1;
                    ctrl_d[C12] = 1'b1;
                end
                state_d = StResult;
            end
            StResult: begin
                ctrl_d[C13] = 1'b1;
                state_d     = (norm_q != 3'd0) ? StDenorm : StDone;
            end
            StDenorm: begin
                ctrl_d[C14] = 1'b1;
                if (norm_q != 3'd0) begin
                    norm_d = norm_q - 3'd1;
                end
                if (norm_q <= 3'd1) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            iter_q  <= 3'd0;
            norm_q  <= 3'd0;
            digit_q <= '0;
            err_q   <= 1'b0;
            ctrl_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            norm_q  <= norm_d;
            digit_q <= digit_d;
            err_q   <= err_d;
            ctrl_q  <= ctrl_d;
            busy_q  <= (state_d != StIdle);
            done_q  <= (state_q == StDone);
        end
    end

    assign bus.ctrl = ctrl_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;

endmodule

// File: doc/srt4_control.md
SRT4_CONTROL -- requirements
Module: srt4_control

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-002 SHALL have ports: start  in  1  begin division, sampled in IDLE only; b_msb  in  1  divisor bit 7; b_zero  in  1  divisor register equals zero; p_top  in  3  P register bits [8:6].
REQ-003 SHALL have ports: ctrl  out  15  datapath strobes c0..c14 (bit n = cn); busy  out  1  operation in progress; done  out  1  one-cycle completion pulse; err  out  1  divide-by-zero flag, held until next start.

Function
REQ-004 SHALL register all outputs; ctrl bits are single-cycle pulses, zero in every cycle not listed below.
REQ-005 SHALL implement the FSM states IDLE, INIT, NORM, SHIFT, ADD, CORRECT, RESULT, DENORM, DONE.
REQ-006 IDLE: start=1 -> INIT, clear err, clear counters; start while busy SHALL be ignored.
REQ-007 INIT (1 cycle): assert c0 and c1; -> NORM.
REQ-008 NORM: b_msb=0 and norm_cnt<7 -> assert c2, norm_cnt+1, stay; otherwise no strobe, -> SHIFT.
REQ-009 SHIFT: decode p_top into a digit: 000/111 -> 0; 001 -> +1; 010/011 -> +2; 110 -> -1; 100/101 -> -2.
REQ-010 SHIFT: assert c3 plus the digit strobe: +1 c4, +2 c7, -1 c5, -2 c6, 0 none; iter_cnt+1.
REQ-011 SHIFT: nonzero digit -> ADD; zero digit -> next SHIFT, or CORRECT when iter_cnt reaches 4.
REQ-012 ADD (1 cycle): assert c8; c9=1 for a positive digit (subtract B); c10=1 for |digit|=2 (2B multiple); -> SHIFT, or CORRECT when iter_cnt=4.
REQ-013 CORRECT (1 cycle): if p_top[2]=1, assert c8, c11 and c12 (restore remainder, decrement quotient); else no strobe; -> RESULT.
REQ-014 RESULT (1 cycle): assert c13; -> DENORM if norm_cnt>0, else DONE.
REQ-015 DENORM: assert c14, norm_cnt-1 each cycle; -> DONE when norm_cnt reaches 0.
REQ-016 DONE (1 cycle): done=1; -> IDLE.
REQ-017 busy SHALL be 1 in every state except IDLE.
REQ-018 iter_cnt and norm_cnt SHALL be 3-bit; neither wraps (limits 4 and 7 are enforced).
REQ-019 Latency from the start-sampling edge to done = 5 + 2k + 4 + (number of nonzero digits) cycles, where k = NORM shifts.

Reset
REQ-020 rst_n=0 SHALL immediately force IDLE with ctrl=0, busy=0, done=0, err=0 and both counters 0, including mid-operation.
REQ-021 After rst_n deasserts, the block SHALL require a new start; no operation resumes.

Configuration
REQ-022 SRT4_DIV0_DETECT_EN defined: in NORM, b_zero=1 SHALL set err=1, emit no strobe and go directly to DONE.
REQ-023 SRT4_DIV0_DETECT_EN undefined: b_zero port is present but ignored, err is constant 0, and a zero divisor runs the full sequence with 7 NORM shifts.

Structure
REQ-024 Package srt4_pkg SHALL hold the state enum, the strobe index constants C0..C14, the digit encoding type, ITER_COUNT=4 and NORM_MAX=7.
REQ-025 Digit decode SHALL be a combinational sub-module srt4_digit_sel (p_top in; digit sign and magnitude out).

Verification
REQ-026 b_msb=1, p_top=000 throughout -> c0|c1 once, no c2, c3 four times with no digit strobe, no c8, c13 once, done at cycle 9.
REQ-027 b_msb=0 for 3 NORM cycles, p_top=010 -> c2 x3, 4 x (c3|c7 then c8|c9|c10), c14 x3, done at cycle 19.
REQ-028 p_top=110 every SHIFT, p_top=100 in CORRECT -> 4 x (c3|c5 then c8 with c9=0 and c10=0); CORRECT asserts c8|c11|c12.
REQ-029 rst_n pulsed low during ADD -> ctrl=0 and busy=0 at once; the next start restarts from INIT.
REQ-030 With the macro defined, b_zero=1 -> err=1 and done at cycle 3; with the macro undefined -> err=0 and 7 x c2.
REQ-031 start held high through a whole operation -> exactly one new operation begins, on the cycle after DONE.
